// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the drive-phase sequencer.
package phase_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AZ,
        ST_PRE,
        ST_ON,
        ST_POST,
        ST_REST
    } state_t;

    // A programmed length of zero still occupies one cycle.
    function automatic int unsigned eff_len(input int unsigned d);
        return (d == 0) ? 32'd1 : d;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts 0..len-1, flags the last cycle, wraps to 0.
module phase_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] len,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    // len is never 0 here, so len-1 is always a reachable count value.
    assign last = (count == len - CNT_W'(1));

    // Count up, restarting on clear or after the terminal cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || last) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/phase_seq_gen.sv
// Multi-channel drive-phase sequencer: auto-zero, per-channel
// dead/on/dead windows, then rest; single-shot or continuous.
module phase_seq_gen
    import phase_seq_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int CNT_W = 6,
    parameter int IDX_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_t_az,
    input  logic [CNT_W-1:0] cfg_t_on,
    input  logic [CNT_W-1:0] cfg_t_dead,
    input  logic [CNT_W-1:0] cfg_t_rest,
    output logic [N_CH-1:0]  ch,
    output logic [N_CH-1:0]  ch_inv,
    output logic             a_zero,
    output logic             rest,
    output logic [CNT_W-1:0] count,
    output logic [IDX_W-1:0] ch_idx,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           nxt_state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_done;
    logic             latch_cfg;
    logic             last;
    logic             last_ch;
    logic             dead_en;
    logic             clear;
    logic             in_win;
    logic [CNT_W-1:0] len;
    logic [N_CH-1:0]  nxt_onehot;

    // Shadow copies: the frame runs on the values captured at its start.
    logic [CNT_W-1:0] sh_az;
    logic [CNT_W-1:0] sh_on;
    logic [CNT_W-1:0] sh_dead;
    logic [CNT_W-1:0] sh_rest;

    assign last_ch = (idx == IDX_W'(N_CH - 1));
    assign dead_en = |sh_dead;
    assign clear   = abort || (state == ST_IDLE);
    assign in_win  = (nxt_state == ST_PRE) || (nxt_state == ST_ON) || (nxt_state == ST_POST);

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .len   (len),
        .count (count),
        .last  (last)
    );

    // Length of the phase currently running.
    always_comb begin
        len = CNT_W'(1);
        case (state)
            ST_AZ:           len = CNT_W'(eff_len(32'(sh_az)));
            ST_PRE, ST_POST: len = CNT_W'(eff_len(32'(sh_dead)));
            ST_ON:           len = CNT_W'(eff_len(32'(sh_on)));
            ST_REST:         len = CNT_W'(eff_len(32'(sh_rest)));
            default:         len = CNT_W'(1);
        endcase
    end

    // Next phase, channel index and frame-end pulse; abort overrides all.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_done  = 1'b0;
        latch_cfg = 1'b0;
        if (abort) begin
            nxt_state = ST_IDLE;
            nxt_idx   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        nxt_state = ST_AZ;
                        latch_cfg = 1'b1;
                    end
                end
                ST_AZ: begin
                    if (last) nxt_state = dead_en ? ST_PRE : ST_ON;
                end
                ST_PRE: begin
                    if (last) nxt_state = ST_ON;
                end
                ST_ON: begin
                    if (last) begin
                        if (dead_en) begin
                            nxt_state = ST_POST;
                        end else if (last_ch) begin
                            nxt_state = ST_REST;
                            nxt_idx   = '0;
                        end else begin
                            nxt_idx = idx + IDX_W'(1);
                        end
                    end
                end
                ST_POST: begin
                    if (last) begin
                        if (last_ch) begin
                            nxt_state = ST_REST;
                            nxt_idx   = '0;
                        end else begin
                            nxt_state = ST_PRE;
                            nxt_idx   = idx + IDX_W'(1);
                        end
                    end
                end
                ST_REST: begin
                    if (last) begin
                        nxt_idx = '0;
                        if (cont) begin
                            nxt_state = ST_AZ;
                            latch_cfg = 1'b1;
                        end else begin
                            nxt_state = ST_IDLE;
                            nxt_done  = 1'b1;
                        end
                    end
                end
                default: begin
                    nxt_state = ST_IDLE;
                    nxt_idx   = '0;
                end
            endcase
        end
    end

    // One-hot select of the channel owning the next window.
    always_comb begin
        nxt_onehot          = '0;
        nxt_onehot[nxt_idx] = 1'b1;
    end

    // Capture timing config at the start of every frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_az   <= '0;
            sh_on   <= '0;
            sh_dead <= '0;
            sh_rest <= '0;
        end else if (latch_cfg) begin
            sh_az   <= cfg_t_az;
            sh_on   <= cfg_t_on;
            sh_dead <= cfg_t_dead;
            sh_rest <= cfg_t_rest;
        end
    end

    // FSM state plus registered output decode of the next phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            ch     <= '0;
            ch_inv <= '0;
            a_zero <= 1'b0;
            rest   <= 1'b0;
            ch_idx <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= nxt_state;
            idx    <= nxt_idx;
            done   <= nxt_done;
            busy   <= (nxt_state != ST_IDLE);
            a_zero <= (nxt_state == ST_AZ);
            rest   <= (nxt_state == ST_REST);
            ch     <= (nxt_state == ST_ON) ? nxt_onehot : '0;
            if (nxt_state == ST_IDLE) begin
                ch_inv <= '0;
            end else if (in_win) begin
                ch_inv <= ~nxt_onehot;
            end else begin
                ch_inv <= '1;
            end
            ch_idx <= in_win ? nxt_idx : '0;
        end
    end

endmodule

// File: tb/tb_phase_seq_gen.sv
// Bench for phase_seq_gen: a 2-channel and a 4-channel instance share
// one stimulus stream; each is compared against a frame-list model.
module tb_phase_seq_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       cont;
    logic       abort;
    logic [5:0] cfg_t_az;
    logic [5:0] cfg_t_on;
    logic [5:0] cfg_t_dead;
    logic [5:0] cfg_t_rest;

    logic [1:0] ch2, chi2;
    logic       az2, rs2, busy2, done2;
    logic [5:0] cnt2;
    logic [0:0] idx2;

    logic [3:0] ch4, chi4;
    logic       az4, rs4, busy4, done4;
    logic [3:0] cnt4;
    logic [1:0] idx4;

    phase_seq_gen #(.N_CH(2), .CNT_W(6), .IDX_W(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
        .cfg_t_az(cfg_t_az), .cfg_t_on(cfg_t_on), .cfg_t_dead(cfg_t_dead), .cfg_t_rest(cfg_t_rest),
        .ch(ch2), .ch_inv(chi2), .a_zero(az2), .rest(rs2), .count(cnt2),
        .ch_idx(idx2), .busy(busy2), .done(done2)
    );

    phase_seq_gen #(.N_CH(4), .CNT_W(4), .IDX_W(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
        .cfg_t_az(cfg_t_az[3:0]), .cfg_t_on(cfg_t_on[3:0]), .cfg_t_dead(cfg_t_dead[3:0]),
        .cfg_t_rest(cfg_t_rest[3:0]),
        .ch(ch4), .ch_inv(chi4), .a_zero(az4), .rest(rs4), .count(cnt4),
        .ch_idx(idx4), .busy(busy4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch; int chi; int az; int rs; int cnt; int idx; int busy; int done; int len;
    } rec_t;

    rec_t q2[$];
    rec_t q4[$];
    rec_t e2, e4;
    int   n_err = 0;
    int   n_chk = 0;
    int   dones2 = 0;
    int   azr2 = 0;
    logic prev_az2 = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic rec_t idle_rec();
        rec_t r;
        r = '{default: 0};
        r.len = 1;
        return r;
    endfunction

    function automatic int eff(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic logic [63:0] pk(input int ch, input int chi, input int az, input int rs,
                                       input int cnt, input int idx, input int busy, input int done);
        return {8'(ch), 8'(chi), 8'(az), 8'(rs), 8'(cnt), 8'(idx), 8'(busy), 8'(done)};
    endfunction

    task automatic q_push(input int which, input rec_t r);
        if (which == 2) q2.push_back(r);
        else q4.push_back(r);
    endtask

    task automatic q_pop(input int which, output rec_t r);
        if (which == 2) r = q2.pop_front();
        else r = q4.pop_front();
    endtask

    // Expand one whole frame into its per-cycle expected outputs.
    task automatic build(input int which);
        int n, m, all, taz, ton, tdd, trs, oh;
        rec_t r;
        n   = (which == 2) ? 2 : 4;
        m   = (which == 2) ? 63 : 15;
        all = (1 << n) - 1;
        taz = eff(int'(cfg_t_az) & m);
        ton = eff(int'(cfg_t_on) & m);
        tdd = int'(cfg_t_dead) & m;
        trs = eff(int'(cfg_t_rest) & m);
        for (int i = 0; i < taz; i++) begin
            r = idle_rec(); r.chi = all; r.az = 1; r.cnt = i; r.busy = 1; r.len = taz;
            q_push(which, r);
        end
        for (int k = 0; k < n; k++) begin
            oh = 1 << k;
            for (int i = 0; i < tdd; i++) begin
                r = idle_rec(); r.chi = all & ~oh; r.idx = k; r.cnt = i; r.busy = 1; r.len = tdd;
                q_push(which, r);
            end
            for (int i = 0; i < ton; i++) begin
                r = idle_rec(); r.ch = oh; r.chi = all & ~oh; r.idx = k; r.cnt = i; r.busy = 1; r.len = ton;
                q_push(which, r);
            end
            for (int i = 0; i < tdd; i++) begin
                r = idle_rec(); r.chi = all & ~oh; r.idx = k; r.cnt = i; r.busy = 1; r.len = tdd;
                q_push(which, r);
            end
        end
        for (int i = 0; i < trs; i++) begin
            r = idle_rec(); r.chi = all; r.rs = 1; r.cnt = i; r.busy = 1; r.len = trs;
            q_push(which, r);
        end
    endtask

    // Advance one model by one clock edge using the inputs sampled there.
    task automatic model_step(input int which);
        rec_t e;
        int   qs;
        e  = (which == 2) ? e2 : e4;
        qs = (which == 2) ? q2.size() : q4.size();
        if (abort) begin
            if (which == 2) q2.delete(); else q4.delete();
            e = idle_rec();
        end else if (e.busy == 0) begin
            if (start) begin
                build(which);
                q_pop(which, e);
            end else begin
                e = idle_rec();
            end
        end else if (qs == 0) begin
            if (cont) begin
                build(which);
                q_pop(which, e);
            end else begin
                e = idle_rec();
                e.done = 1;
            end
        end else begin
            q_pop(which, e);
        end
        if (which == 2) e2 = e; else e4 = e;
    endtask

    task automatic model_reset();
        q2.delete();
        q4.delete();
        e2 = idle_rec();
        e4 = idle_rec();
    endtask

    // One clock: model update at the edge, compare 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_step(2);
        model_step(4);
        #1;
        check_eq("dut2", pk(int'(ch2), int'(chi2), int'(az2), int'(rs2), int'(cnt2), int'(idx2),
                            int'(busy2), int'(done2)),
                 pk(e2.ch, e2.chi, e2.az, e2.rs, e2.cnt, e2.idx, e2.busy, e2.done));
        check_eq("dut4", pk(int'(ch4), int'(chi4), int'(az4), int'(rs4), int'(cnt4), int'(idx4),
                            int'(busy4), int'(done4)),
                 pk(e4.ch, e4.chi, e4.az, e4.rs, e4.cnt, e4.idx, e4.busy, e4.done));
        check_eq("ovl2", 64'(ch2 & chi2), 64'd0);
        check_eq("ovl4", 64'(ch4 & chi4), 64'd0);
        check_eq("onehot4", 64'($countones(ch4) <= 1), 64'd1);
        check_eq("cntlen4", 64'(int'(cnt4) < e4.len), 64'd1);
        if (done2) dones2++;
        if (az2 && !prev_az2) azr2++;
        prev_az2 = az2;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((busy2 || busy4) && n < bound) begin
            step();
            n++;
        end
        check_eq("idle_wait", 64'(busy2 | busy4), 64'd0);
    endtask

    function automatic logic [5:0] rnd_cfg();
        int r;
        r = $urandom_range(0, 5);
        if (r == 0) return 6'd0;
        if (r == 1) return 6'd15;
        return 6'($urandom_range(1, 7));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0;
        cfg_t_az = 6'd2; cfg_t_dead = 6'd1; cfg_t_on = 6'd3; cfg_t_rest = 6'd2;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst2", pk(int'(ch2), int'(chi2), int'(az2), int'(rs2), int'(cnt2), int'(idx2),
                            int'(busy2), int'(done2)), 64'd0);
        check_eq("rst4", pk(int'(ch4), int'(chi4), int'(az4), int'(rs4), int'(cnt4), int'(idx4),
                            int'(busy4), int'(done4)), 64'd0);
        rst_n = 1'b1;
        step();

        // Single-shot timeline against fixed cycle offsets from the start edge.
        start = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            step();
            start = 1'b0;
            case (j)
                1, 2:      check_eq("ss_az", 64'(az2), 64'd1);
                3:         check_eq("ss_pre0", 64'({ch2, chi2}), 64'b0010);
                4, 5, 6:   check_eq("ss_on0", 64'(ch2), 64'd1);
                7, 8:      check_eq("ss_dead", 64'(ch2), 64'd0);
                9, 10, 11: check_eq("ss_on1", 64'(ch2), 64'd2);
                13, 14:    check_eq("ss_rest", 64'(rs2), 64'd1);
                15:        check_eq("ss_done", 64'({done2, busy2}), 64'b10);
                16:        check_eq("ss_after", 64'({done2, busy2}), 64'b00);
                default:   check_eq("ss_busy", 64'(busy2), 64'd1);
            endcase
        end
        wait_idle(100);

        // Zero dead time: ch[0] window hands over to ch[1] on a single edge.
        begin
            logic prev01, saw;
            prev01 = 1'b0; saw = 1'b0;
            cfg_t_dead = 6'd0; cfg_t_on = 6'd2;
            start = 1'b1;
            for (int j = 0; j < 14; j++) begin
                step();
                start = 1'b0;
                if (prev01 && ch2 == 2'b10 && chi2 == 2'b01) saw = 1'b1;
                prev01 = (ch2 == 2'b01);
            end
            check_eq("dz_abut", 64'(saw), 64'd1);
            wait_idle(100);
        end

        // Continuous: three frames, t_on changed mid-frame, one done at the end.
        cfg_t_dead = 6'd1; cfg_t_on = 6'd3;
        dones2 = 0; azr2 = 0;
        cont = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 0; n < 300 && !(azr2 >= 3 && !busy2); n++) begin
            if (n == 5) cfg_t_on = 6'd5;
            if (azr2 >= 3) cont = 1'b0;
            step();
        end
        cont = 1'b0;
        check_eq("cont_frames", 64'(azr2), 64'd3);
        check_eq("cont_done", 64'(dones2), 64'd1);
        wait_idle(200);

        // Abort during ON(1), then a fresh frame runs to completion.
        begin
            int n;
            n = 0;
            start = 1'b1;
            step();
            start = 1'b0;
            while (ch2 != 2'b10 && n < 40) begin
                step();
                n++;
            end
            check_eq("ab_reach", 64'(ch2), 64'd2);
            abort = 1'b1;
            step();
            abort = 1'b0;
            check_eq("ab_out", 64'({ch2, chi2, busy2, done2}), 64'd0);
            dones2 = 0;
            start = 1'b1;
            step();
            start = 1'b0;
            wait_idle(200);
            check_eq("ab_rerun", 64'(dones2), 64'd1);
        end

        // Randomised control and config traffic.
        for (int i = 0; i < 500; i++) begin
            start = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 60) == 0);
            cont  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) begin
                cfg_t_az = rnd_cfg(); cfg_t_on = rnd_cfg();
                cfg_t_dead = rnd_cfg(); cfg_t_rest = rnd_cfg();
            end
            step();
        end
        start = 1'b0; cont = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;

        // Reset asserted mid-frame clears outputs without a clock edge.
        cfg_t_az = 6'd2; cfg_t_dead = 6'd1; cfg_t_on = 6'd3; cfg_t_rest = 6'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 5; j++) step();
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid2", pk(int'(ch2), int'(chi2), int'(az2), int'(rs2), int'(cnt2), int'(idx2),
                                int'(busy2), int'(done2)), 64'd0);
        check_eq("rst_mid4", pk(int'(ch4), int'(chi4), int'(az4), int'(rs4), int'(cnt4), int'(idx4),
                                int'(busy4), int'(done4)), 64'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int j = 0; j < 3; j++) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
